// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A multiply takes 32 shift-add steps. A divide takes 32 restoring
// shift-subtract steps. Both work on operand magnitudes, and the sign is
// fixed up on the transition into DONE.
// Optional macro MULDIV_SPECIAL_FAST_EN: a divide by zero or a signed
// 0x80000000 / -1 completes straight from IDLE to DONE.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  Funct3,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] a_q, b_q, mag_q;
    logic [2:0]  f3_q;
    logic [63:0] acc_q, acc_n;
    logic [4:0]  cnt_q;
    logic        load, fin;
    logic [31:0] res_fin;

    // operand signedness / magnitudes of the incoming instruction
    logic        a_sgn_in, b_sgn_in;
    logic [31:0] mag_a_in, mag_b_in;
    // signedness of the latched instruction
    logic        a_neg_q, b_neg_q;
    // single-step datapath
    logic [32:0] mul_sum;
    logic [63:0] mul_next, prod_s;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    logic [31:0] quo_s, rem_s;

`ifdef MULDIV_SPECIAL_FAST_EN
    logic        fast, fast_hit;
    logic [31:0] fast_res;
`endif

    // operand preparation for the start cycle and sign flags of the latched op
    always_comb begin
        a_sgn_in = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
        b_sgn_in = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
        mag_a_in = (a_sgn_in & SrcA[31]) ? (32'd0 - SrcA) : SrcA;
        mag_b_in = (b_sgn_in & SrcB[31]) ? (32'd0 - SrcB) : SrcB;
        a_neg_q  = ((f3_q == 3'b001) | (f3_q == 3'b010) | (f3_q == 3'b100) | (f3_q == 3'b110)) & a_q[31];
        b_neg_q  = ((f3_q == 3'b001) | (f3_q == 3'b100) | (f3_q == 3'b110)) & b_q[31];
    end

    // one iteration step: shift-add for MUL, restoring shift-subtract for DIV
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        div_sh   = {acc_q[63:32], acc_q[31]};
        div_ge   = (div_sh >= {1'b0, mag_q});
        // the true difference is below 2^32 whenever div_ge holds
        div_sub  = div_sh[31:0] - mag_q;
        div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                          : {div_sh[31:0], acc_q[30:0], 1'b0};
        acc_n    = (state == MUL) ? mul_next : div_next;
    end

    // final result with sign correction, taken from the last step's output
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? (64'd0 - mul_next) : mul_next;
        quo_s  = (a_neg_q ^ b_neg_q) ? (32'd0 - div_next[31:0]) : div_next[31:0];
        rem_s  = a_neg_q ? (32'd0 - div_next[63:32]) : div_next[63:32];
        if (state == MUL) begin
            res_fin = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
        end else if (b_q == 32'd0) begin
            res_fin = f3_q[1] ? a_q : '1;
        end else begin
            res_fin = f3_q[1] ? rem_s : quo_s;
        end
    end

`ifdef MULDIV_SPECIAL_FAST_EN
    // cases whose result is known without iterating
    always_comb begin
        fast_hit = Funct3[2] & ((SrcB == 32'd0) |
                   (~Funct3[0] & (SrcA == 32'h8000_0000) & (SrcB == 32'hFFFF_FFFF)));
        if (SrcB == 32'd0) fast_res = Funct3[1] ? SrcA : '1;
        else               fast_res = Funct3[1] ? '0 : 32'h8000_0000;
    end
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state and control outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        fin     = 1'b0;
`ifdef MULDIV_SPECIAL_FAST_EN
        fast    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_n = Funct3[2] ? DIV : MUL;
`ifdef MULDIV_SPECIAL_FAST_EN
                    if (fast_hit) begin
                        fast    = 1'b1;
                        state_n = DONE;
                    end
`endif
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt_q == 5'd0) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // operand latch, iteration registers and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            f3_q   <= '0;
            mag_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            Result <= '0;
        end else begin
            if (load) begin
                a_q   <= SrcA;
                b_q   <= SrcB;
                f3_q  <= Funct3;
                cnt_q <= 5'd31;
                mag_q <= Funct3[2] ? mag_b_in : mag_a_in;
                acc_q <= {32'd0, (Funct3[2] ? mag_a_in : mag_b_in)};
            end else if (busy) begin
                acc_q <= acc_n;
                if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
            end
            if (fin) Result <= res_fin;
`ifdef MULDIV_SPECIAL_FAST_EN
            if (fast) Result <= fast_res;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit.
// Compile with the same MULDIV_SPECIAL_FAST_EN setting as the RTL.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] Result;

`ifdef MULDIV_SPECIAL_FAST_EN
    localparam int SPL = 1;
`else
    localparam int SPL = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          scyc;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        checks++;
        $display("FAIL %s: timed out", nm);
    endtask

    // monitor: on every done pulse, pop and compare result, latency and busy length
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                timeout("unexpected_done");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_res"}, {32'd0, Result}, {32'd0, e.res});
                chk({e.name, "_lat"}, 64'(cyc - e.scyc + 1), 64'(e.lat));
                chk({e.name, "_busy"}, 64'(busy_cnt), 64'(e.lat - 1));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt = busy_cnt + 1;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        if (k == 200) timeout("wait_idle");
    endtask

    // issue one op; when push is set the expected response goes on the scoreboard
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push, input string nm);
        exp_t e;
        wait_idle();
        Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.res = exp; e.lat = lat; e.scyc = cyc; e.name = nm;
            sbq.push_back(e);
            last_exp = exp;
        end
    endtask

    initial begin
        int w;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, Result}, 64'd0);
        @(negedge clk); reset = 1'b0;

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1, "mulh_min");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1, "rem_m7_2");
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1, "mul_ff");
        issue(3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, SPL, 1, "divu_z");
        issue(3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, SPL, 1, "remu_z");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL, 1, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPL, 1, "rem_ovf");
        issue(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SPL, 1, "div_z");
        issue(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPL, 1, "rem_z");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1, "mulhsu");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, "mulhu");
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1, "mulh_m1");
        issue(3'b000, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 33, 1, "mul_sh");
        issue(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1, "div_7_m2");
        issue(3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33, 1, "rem_7_m2");
        issue(3'b101, 32'd100,       32'd7,         32'h0000_000E, 33, 1, "divu_100_7");
        issue(3'b111, 32'd100,       32'd7,         32'h0000_0002, 33, 1, "remu_100_7");

        // flush 10 cycles into a divide: back to IDLE, no done, Result held
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 33, 0, "flushed");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_result", {32'd0, Result}, {32'd0, last_exp});
        @(negedge clk);
        // flush beats a simultaneous start in IDLE
        start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
        @(posedge clk); #1;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); flush = 1'b0; start = 1'b0;
        issue(3'b100, 32'd1000, 32'd3, 32'd333, 33, 1, "after_flush");

        // start held high through busy and DONE is ignored
        wait_idle();
        Funct3 = 3'b000; SrcA = 32'd6; SrcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        begin
            exp_t e;
            e.res = 32'd42; e.lat = 33; e.scyc = cyc; e.name = "held_start";
            sbq.push_back(e);
        end
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (done) break;
        end
        if (w == 100) timeout("held_done");
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_no_restart", {63'd0, busy}, 64'd0);

        // reset in the middle of a multiply
        issue(3'b000, 32'h0000_1234, 32'h0000_5678, 32'd0, 33, 0, "reset_mul");
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", {32'd0, Result}, 64'd0);
        @(negedge clk); reset = 1'b0;
        // started on the first rising edge after reset release
        Funct3 = 3'b000; SrcA = 32'h0000_1234; SrcB = 32'h0000_5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            exp_t e;
            e.res = 32'h0626_0060; e.lat = 33; e.scyc = cyc; e.name = "post_reset";
            sbq.push_back(e);
        end

        // drain the scoreboard
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) timeout("drain");
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
